// File: rtl/csi2_tx_pkg.sv
// Shared types for the CSI-2 transmit lane distributor.
//   tx_state_e   : distributor FSM states
//   ENTRY_W      : byte FIFO entry width ({last, data})
//   fifo_entry_t : packed FIFO entry payload
package csi2_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

  localparam int unsigned ENTRY_W = 9;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/csi2_byte_fifo.sv
// Synchronous byte FIFO with 0/1/2-entry pop and two-entry head peek.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, push_entry  write one entry per cycle
//   pop_cnt           entries removed this cycle (0..2, never more than level)
//   head, head_next   entries at read pointer and read pointer + 1
//   level             registered occupancy
//   ready             registered "not full" for the next cycle; 0 in reset
module csi2_byte_fifo
  import csi2_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fifo_entry_t                push_entry,
  input  logic [1:0]                 pop_cnt,
  output fifo_entry_t                head,
  output fifo_entry_t                head_next,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr_p1;
  logic [LW-1:0]      level_nxt;

  // Next occupancy; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    level_nxt = level + LW'(push) - LW'(pop_cnt);
    rd_ptr_p1 = rd_ptr + AW'(1);
  end

  assign head      = fifo_entry_t'(mem[rd_ptr]);
  assign head_next = fifo_entry_t'(mem[rd_ptr_p1]);

  // Storage array, no reset needed: contents are qualified by level
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ENTRY_W'(push_entry);
    end
  end

  // Pointers, level and registered ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      ready  <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_cnt);
      wr_ptr <= wr_ptr + AW'(push);
      level  <= level_nxt;
      ready  <= (level_nxt != LW'(DEPTH));
    end
  end

endmodule

// File: rtl/csi2_lane_distributor.sv
// CSI-2 TX lane distributor: buffers the packet byte stream, runs the HS
// request/ready handshake with the D-PHY and stripes bytes across two lanes
// (even bytes on lane 0, odd bytes on lane 1), inserting an LP gap between
// packets.
// Ports:
//   byteclk, resetn                 clock, async active-low reset
//   in_data/in_valid/in_last/in_ready  packet byte input stream
//   txrequest_hs, txready_hs        HS handshake with the PHY
//   txwrite_hs, lane{0,1}_byte/valid  lane beat output
//   busy, pkt_done, stall, fifo_level  status
module csi2_lane_distributor
  import csi2_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned START_LEVEL = 16,
  parameter int unsigned GAP_CYC     = 8
) (
  input  logic                          byteclk,
  input  logic                          resetn,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          txrequest_hs,
  output logic                          txwrite_hs,
  output logic [7:0]                    lane0_byte,
  output logic                          lane0_valid,
  output logic [7:0]                    lane1_byte,
  output logic                          lane1_valid,
  input  logic                          txready_hs,
  output logic                          busy,
  output logic                          pkt_done,
  output logic                          stall,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  tx_state_e    state;
  fifo_entry_t  head;
  fifo_entry_t  head_next;
  fifo_entry_t  push_entry;
  logic         push_c;
  logic [1:0]   pop_cnt_c;
  logic         last_beat_c;
  logic [LW-1:0] pkt_cnt;
  logic [GW-1:0] gap_cnt;

  csi2_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (byteclk),
    .rst_n      (resetn),
    .push       (push_c),
    .push_entry (push_entry),
    .pop_cnt    (pop_cnt_c),
    .head       (head),
    .head_next  (head_next),
    .level      (fifo_level),
    .ready      (in_ready)
  );

  // Beat selection: a last byte at the head always goes out alone on lane 0
  // so the next packet restarts at an even index; otherwise wait for a pair.
  always_comb begin
    push_c          = in_valid && in_ready;
    push_entry.last = in_last;
    push_entry.data = in_data;
    pop_cnt_c       = 2'd0;
    if (state == SEND && txready_hs) begin
      if (fifo_level != '0 && head.last) begin
        pop_cnt_c = 2'd1;
      end else if (fifo_level >= LW'(2)) begin
        pop_cnt_c = 2'd2;
      end
    end
    last_beat_c = (pop_cnt_c == 2'd1) || (pop_cnt_c == 2'd2 && head_next.last);
  end

  // Count of complete packets resident in the FIFO
  always_ff @(posedge byteclk or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt <= '0;
    end else begin
      case ({push_c && in_last, last_beat_c})
        2'b10:   pkt_cnt <= pkt_cnt + LW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - LW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Distributor FSM with registered lane and status outputs
  always_ff @(posedge byteclk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      txrequest_hs <= 1'b0;
      txwrite_hs   <= 1'b0;
      lane0_byte   <= '0;
      lane0_valid  <= 1'b0;
      lane1_byte   <= '0;
      lane1_valid  <= 1'b0;
      busy         <= 1'b0;
      pkt_done     <= 1'b0;
      stall        <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      txwrite_hs  <= 1'b0;
      lane0_valid <= 1'b0;
      lane1_valid <= 1'b0;
      pkt_done    <= 1'b0;
      stall       <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_cnt != '0 || fifo_level >= LW'(START_LEVEL)) begin
            state        <= REQ;
            txrequest_hs <= 1'b1;
            busy         <= 1'b1;
          end
        end
        REQ: begin
          if (txready_hs) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (pop_cnt_c != 2'd0) begin
            txwrite_hs  <= 1'b1;
            lane0_byte  <= head.data;
            lane0_valid <= 1'b1;
            if (pop_cnt_c == 2'd2) begin
              lane1_byte  <= head_next.data;
              lane1_valid <= 1'b1;
            end else begin
              lane1_byte <= '0;
            end
            if (last_beat_c) begin
              state   <= GAP;
              gap_cnt <= GW'(GAP_CYC);
            end
          end else begin
            stall <= 1'b1;
          end
        end
        GAP: begin
          // Request stays high through the final beat, then drops here
          txrequest_hs <= 1'b0;
          pkt_done     <= (gap_cnt == GW'(GAP_CYC));
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_lane_distributor.sv
// Scoreboard bench for csi2_lane_distributor: stimulus queues expected lane
// beats, a monitor compares every txwrite_hs beat against the queue head.
module tb_csi2_lane_distributor;

  localparam int unsigned GAP = 8;

  logic       byteclk;
  logic       resetn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       txrequest_hs;
  logic       txwrite_hs;
  logic [7:0] lane0_byte;
  logic       lane0_valid;
  logic [7:0] lane1_byte;
  logic       lane1_valid;
  logic       txready_hs;
  logic       busy;
  logic       pkt_done;
  logic       stall;
  logic [6:0] fifo_level;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [16:0] exp_q[$];
  int          stall_seen = 0;
  logic        prev_write = 1'b0;
  int          req_cnt = 0;
  logic        hold_off = 1'b0;

  csi2_lane_distributor #(
    .FIFO_DEPTH (64),
    .START_LEVEL(16),
    .GAP_CYC    (GAP)
  ) dut (
    .byteclk     (byteclk),
    .resetn      (resetn),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .txrequest_hs(txrequest_hs),
    .txwrite_hs  (txwrite_hs),
    .lane0_byte  (lane0_byte),
    .lane0_valid (lane0_valid),
    .lane1_byte  (lane1_byte),
    .lane1_valid (lane1_valid),
    .txready_hs  (txready_hs),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .stall       (stall),
    .fifo_level  (fifo_level)
  );

  initial byteclk = 1'b0;
  always #5 byteclk = ~byteclk;

  // PHY model: ready six cycles after request rises, drops with request
  assign txready_hs = (req_cnt >= 6) && !hold_off;
  always @(negedge byteclk) begin
    if (!txrequest_hs) req_cnt <= 0;
    else if (req_cnt < 6) req_cnt <= req_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add_beat(input logic [7:0] l0, input logic l1v, input logic [7:0] l1);
    exp_q.push_back({l0, l1v, l1});
  endtask

  // Monitor: compare each written beat against the scoreboard head
  always @(negedge byteclk) begin
    prev_write <= txwrite_hs;
    if (resetn) begin
      if (txwrite_hs) begin
        check("beat_expected", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
          check("lane0_byte",  32'(lane0_byte),  32'(exp_q[0][16:9]));
          check("lane0_valid", 32'(lane0_valid), 32'(1));
          check("lane1_valid", 32'(lane1_valid), 32'(exp_q[0][8]));
          check("lane1_byte",  32'(lane1_byte),  32'(exp_q[0][7:0]));
          check("req_during_write", 32'(txrequest_hs), 32'(1));
          exp_q.delete(0);
        end
      end
      if (stall) begin
        stall_seen <= stall_seen + 1;
        check("stall_no_write", 32'({txwrite_hs, lane0_valid, lane1_valid}), 32'(0));
      end
    end
  end

  // Called at a negedge; returns at a negedge after the byte was pushed
  task automatic push_byte(input logic [7:0] d, input logic l);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge byteclk);
      w++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge byteclk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_pkt(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) push_byte(base + 8'(i), (i == n - 1));
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!pkt_done && w < 400) begin
      @(negedge byteclk);
      w++;
    end
    check("pkt_done_seen", 32'(pkt_done), 32'(1));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 400) begin
      @(negedge byteclk);
      w++;
    end
    check("back_to_idle", 32'(busy), 32'(0));
  endtask

  task automatic wait_write();
    int w;
    w = 0;
    while (!txwrite_hs && w < 400) begin
      @(negedge byteclk);
      w++;
    end
    check("first_beat_seen", 32'(txwrite_hs), 32'(1));
  endtask

  initial begin
    int low;
    int stall0;
    logic [6:0] lvl;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    repeat (3) @(negedge byteclk);
    check("reset_outputs", 32'({in_ready, txrequest_hs, txwrite_hs, lane0_valid,
                                lane1_valid, busy, pkt_done, stall}), 32'(0));
    check("reset_lanes", 32'({lane0_byte, lane1_byte}), 32'(0));
    check("reset_level", 32'(fifo_level), 32'(0));
    resetn = 1'b1;
    @(negedge byteclk);
    check("in_ready_after_reset", 32'(in_ready), 32'(1));

    // 8-byte packet: four full pairs
    add_beat(8'h00, 1'b1, 8'h01);
    add_beat(8'h02, 1'b1, 8'h03);
    add_beat(8'h04, 1'b1, 8'h05);
    add_beat(8'h06, 1'b1, 8'h07);
    push_pkt(8'h00, 8);
    wait_done();
    check("req_drop_after_last", 32'({prev_write, txrequest_hs, txwrite_hs}), 32'(3'b100));
    @(negedge byteclk);
    check("pkt_done_single", 32'(pkt_done), 32'(0));
    wait_idle();
    check("t1_drained", 32'(exp_q.size()), 32'(0));

    // 5-byte packet: odd tail goes out on lane 0 alone
    add_beat(8'hA0, 1'b1, 8'hA1);
    add_beat(8'hA2, 1'b1, 8'hA3);
    add_beat(8'hA4, 1'b0, 8'h00);
    push_pkt(8'hA0, 5);
    wait_done();
    wait_idle();
    check("t2_drained", 32'(exp_q.size()), 32'(0));

    // Back-to-back 3-byte packets
    add_beat(8'h10, 1'b1, 8'h11);
    add_beat(8'h12, 1'b0, 8'h00);
    add_beat(8'h20, 1'b1, 8'h21);
    add_beat(8'h22, 1'b0, 8'h00);
    push_pkt(8'h10, 3);
    push_pkt(8'h20, 3);
    wait_done();
    check("p2_held_in_fifo", 32'(fifo_level), 32'(3));
    low = 0;
    while (!txrequest_hs && low < 100) begin
      low++;
      @(negedge byteclk);
    end
    check("gap_len_ok", 32'(low >= int'(GAP)), 32'(1));
    check("req_after_gap", 32'(txrequest_hs), 32'(1));
    wait_done();
    wait_idle();
    check("t3_drained", 32'(exp_q.size()), 32'(0));

    // Streaming without last: start at level 16, then starve the output
    stall0 = stall_seen;
    for (int i = 0; i < 24; i += 2) add_beat(8'h40 + 8'(i), 1'b1, 8'h41 + 8'(i));
    add_beat(8'h58, 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) push_byte(8'h40 + 8'(i), 1'b0);
    repeat (3) @(negedge byteclk);
    check("no_req_below_start", 32'(txrequest_hs), 32'(0));
    check("level_15", 32'(fifo_level), 32'(15));
    push_byte(8'h4F, 1'b0);
    low = 0;
    while (!txrequest_hs && low < 20) begin
      low++;
      @(negedge byteclk);
    end
    check("req_at_start_level", 32'(txrequest_hs), 32'(1));
    check("level_at_req", 32'(fifo_level), 32'(16));
    for (int i = 0; i < 8; i++) begin
      push_byte(8'h50 + 8'(i), 1'b0);
      repeat (2) @(negedge byteclk);
    end
    push_byte(8'h58, 1'b1);
    wait_done();
    wait_idle();
    check("stall_seen", 32'(stall_seen > stall0), 32'(1));
    check("t4_drained", 32'(exp_q.size()), 32'(0));

    // PHY not ready for 4 cycles mid-SEND
    add_beat(8'h60, 1'b1, 8'h61);
    add_beat(8'h62, 1'b1, 8'h63);
    add_beat(8'h64, 1'b1, 8'h65);
    add_beat(8'h66, 1'b1, 8'h67);
    push_pkt(8'h60, 8);
    wait_write();
    hold_off = 1'b1;
    lvl = fifo_level;
    for (int i = 0; i < 4; i++) begin
      @(negedge byteclk);
      check("hold_stall", 32'(stall), 32'(1));
      check("hold_no_write", 32'(txwrite_hs), 32'(0));
      check("hold_no_pop", 32'(fifo_level), 32'(lvl));
    end
    hold_off = 1'b0;
    wait_done();
    wait_idle();
    check("t5_drained", 32'(exp_q.size()), 32'(0));

    // Reset mid-SEND, then a clean 4-byte packet
    add_beat(8'h70, 1'b1, 8'h71);
    push_pkt(8'h70, 8);
    wait_write();
    #2;
    resetn = 1'b0;
    #1;
    check("rst_req_async", 32'(txrequest_hs), 32'(0));
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_write", 32'(txwrite_hs), 32'(0));
    exp_q.delete();
    repeat (2) @(negedge byteclk);
    resetn = 1'b1;
    @(negedge byteclk);
    check("in_ready_after_rst2", 32'(in_ready), 32'(1));
    add_beat(8'h80, 1'b1, 8'h81);
    add_beat(8'h82, 1'b1, 8'h83);
    push_pkt(8'h80, 4);
    wait_done();
    wait_idle();
    check("t6_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
